// File: rtl/wb_spi_flash_rd.sv
// Read-only Wishbone B3 classic slave that serves 32-bit words from SPI NOR flash (READ 0x03).
// Consecutive word reads keep chip select low and continue the flash stream without a new command.
module wb_spi_flash_rd #(
    parameter int unsigned CLK_DIV        = 1,
    parameter logic [23:0] FLASH_BASE     = 24'h100000,
    parameter int unsigned CS_HIGH_CYCLES = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        o_spi_cs_n,
    output logic        o_spi_clk,
    output logic        o_spi_mosi,
    input  logic        i_spi_miso
);

    // IDLE wait for req | CSHI cs_n high gap | CMD shift 03+addr | DATA shift in word | ACK one-cycle ack
    typedef enum logic [2:0] {IDLE, CSHI, CMD, DATA, ACK} state_t;

    localparam logic [15:0] DIV_LOAD = 16'(CLK_DIV - 1);
    localparam logic [15:0] CSH_LOAD = 16'(CS_HIGH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic [4:0]  bit_q, bit_d;
    logic        phase_q, phase_d;
    logic [31:0] sr_q, sr_d;
    logic [23:0] fa_q, fa_d;
    logic [23:0] next_fa_q, next_fa_d;
    logic        stream_q, stream_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;

    logic        req;
    logic [23:0] fa_req;
    logic        unused_ok;

    assign fa_req    = FLASH_BASE + {wb_adr_i[23:2], 2'b00};
    assign req       = wb_cyc_i & wb_stb_i & ~ack_q;
    assign unused_ok = ^{wb_adr_i[31:24], wb_adr_i[1:0], wb_dat_i, wb_sel_i};

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        sr_d      = sr_q;
        fa_d      = fa_q;
        next_fa_d = next_fa_q;
        stream_d  = stream_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        ack_d     = 1'b0;
        dat_d     = dat_q;

        case (state_q)
            IDLE: begin
                if (req && wb_we_i) begin
                    ack_d = 1'b1;
                end else if (req) begin
                    fa_d    = fa_req;
                    tmr_d   = DIV_LOAD;
                    bit_d   = 5'd31;
                    phase_d = 1'b0;
                    if (stream_q && (fa_req == next_fa_q)) begin
                        mosi_d  = 1'b0;
                        state_d = DATA;
                    end else if (stream_q) begin
                        cs_n_d   = 1'b1;
                        stream_d = 1'b0;
                        tmr_d    = CSH_LOAD;
                        state_d  = CSHI;
                    end else begin
                        cs_n_d  = 1'b0;
                        sr_d    = {8'h03, fa_req};
                        mosi_d  = sr_d[31];
                        state_d = CMD;
                    end
                end
            end
            CSHI: begin
                if (tmr_q == 16'd0) begin
                    cs_n_d  = 1'b0;
                    sr_d    = {8'h03, fa_q};
                    mosi_d  = sr_d[31];
                    tmr_d   = DIV_LOAD;
                    bit_d   = 5'd31;
                    phase_d = 1'b0;
                    state_d = CMD;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            CMD, DATA: begin
                if (tmr_q != 16'd0) begin
                    tmr_d = tmr_q - 16'd1;
                end else begin
                    tmr_d = DIV_LOAD;
                    if (!phase_q) begin
                        sck_d   = 1'b1;
                        phase_d = 1'b1;
                        if (state_q == DATA) begin
                            sr_d = {sr_q[30:0], i_spi_miso};
                        end
                    end else begin
                        sck_d   = 1'b0;
                        phase_d = 1'b0;
                        if (bit_q != 5'd0) begin
                            bit_d = bit_q - 5'd1;
                            if (state_q == CMD) begin
                                sr_d   = {sr_q[30:0], 1'b0};
                                mosi_d = sr_q[30];
                            end
                        end else if (state_q == CMD) begin
                            bit_d   = 5'd31;
                            mosi_d  = 1'b0;
                            state_d = DATA;
                        end else begin
                            // first byte on the wire is the lowest flash address
                            dat_d   = {sr_q[7:0], sr_q[15:8], sr_q[23:16], sr_q[31:24]};
                            ack_d   = 1'b1;
                            state_d = ACK;
                        end
                    end
                end
            end
            ACK: begin
                next_fa_d = fa_q + 24'd4;
                stream_d  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!wb_cyc_i && (state_q == CSHI || state_q == CMD || state_q == DATA)) begin
            state_d  = IDLE;
            cs_n_d   = 1'b1;
            sck_d    = 1'b0;
            mosi_d   = 1'b0;
            phase_d  = 1'b0;
            stream_d = 1'b0;
            ack_d    = 1'b0;
            dat_d    = dat_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            tmr_q     <= 16'd0;
            bit_q     <= 5'd0;
            phase_q   <= 1'b0;
            sr_q      <= 32'd0;
            fa_q      <= 24'd0;
            next_fa_q <= 24'd0;
            stream_q  <= 1'b0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            sr_q      <= sr_d;
            fa_q      <= fa_d;
            next_fa_q <= next_fa_d;
            stream_q  <= stream_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign o_spi_cs_n = cs_n_q;
    assign o_spi_clk  = sck_q;
    assign o_spi_mosi = mosi_q;

endmodule

// File: tb/tb_wb_spi_flash_rd.sv
// Bench for wb_spi_flash_rd: two instances (CLK_DIV 1 and 3) against a behavioural SPI flash
// and a transaction-level model of latency, stream state and returned data.
module tb_wb_spi_flash_rd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, sel = 1'b0;
    logic [31:0] adr = 32'd0;

    wire [1:0]  cs_n_w, sck_w, mosi_w, miso_w, ack_w;
    wire [31:0] dat_w0, dat_w1;

    wb_spi_flash_rd #(.CLK_DIV(1), .FLASH_BASE(24'h100000), .CS_HIGH_CYCLES(4)) u_d1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(32'hDEADBEEF),
        .wb_sel_i(4'hF), .wb_we_i(we), .wb_cyc_i(cyc & ~sel), .wb_stb_i(stb & ~sel),
        .wb_dat_o(dat_w0), .wb_ack_o(ack_w[0]), .o_spi_cs_n(cs_n_w[0]),
        .o_spi_clk(sck_w[0]), .o_spi_mosi(mosi_w[0]), .i_spi_miso(miso_w[0]));

    wb_spi_flash_rd #(.CLK_DIV(3), .FLASH_BASE(24'h100000), .CS_HIGH_CYCLES(4)) u_d3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(32'hDEADBEEF),
        .wb_sel_i(4'hF), .wb_we_i(we), .wb_cyc_i(cyc & sel), .wb_stb_i(stb & sel),
        .wb_dat_o(dat_w1), .wb_ack_o(ack_w[1]), .o_spi_cs_n(cs_n_w[1]),
        .o_spi_clk(sck_w[1]), .o_spi_mosi(mosi_w[1]), .i_spi_miso(miso_w[1]));

    wire        cs_n_s = sel ? cs_n_w[1] : cs_n_w[0];
    wire        sck_s  = sel ? sck_w[1]  : sck_w[0];
    wire        mosi_s = sel ? mosi_w[1] : mosi_w[0];
    wire        ack_s  = sel ? ack_w[1]  : ack_w[0];
    wire [31:0] dat_s  = sel ? dat_w1    : dat_w0;

    // Sparse flash contents; unwritten bytes get a random value on first touch.
    logic [7:0] mem [int unsigned];

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        int unsigned k = 32'(a);
        if (!mem.exists(k)) mem[k] = 8'($urandom_range(0, 255));
        return mem[k];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_fl
        int          nbits = 0;
        int          idx = 0;
        int          ncmd = 0;
        logic [31:0] cmd_sr = 32'd0;
        logic [31:0] last_cmd = 32'd0;
        logic        sck_p = 1'b0;
        logic        miso_r = 1'b0;
        logic [7:0]  byte_v;
        assign miso_w[g] = miso_r;

        always @(cs_n_w[g] or sck_w[g]) begin
            if (cs_n_w[g] !== 1'b0) begin
                nbits = 0;
                idx   = 0;
            end else if (sck_w[g] && !sck_p) begin
                if (nbits < 32) begin
                    cmd_sr = {cmd_sr[30:0], mosi_w[g]};
                    nbits++;
                    if (nbits == 32) begin
                        last_cmd = cmd_sr;
                        ncmd++;
                    end
                end else begin
                    idx++;
                end
            end else if (!sck_w[g] && sck_p && nbits == 32) begin
                byte_v = mem_rd(last_cmd[23:0] + 24'(idx / 8));
                miso_r = byte_v[7 - (idx % 8)];
            end
            sck_p = sck_w[g];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic        model_open [2];
    logic [23:0] model_next [2];

    function automatic int get_ncmd(input int d);
        return d ? g_fl[1].ncmd : g_fl[0].ncmd;
    endfunction

    function automatic logic [31:0] get_cmd(input int d);
        return d ? g_fl[1].last_cmd : g_fl[0].last_cmd;
    endfunction

    task automatic do_op(input int d, input bit wr, input logic [31:0] a, input string tag);
        int          lat = 0, cs_hi = 0, rises = 0, last_rise = 0, bad_period = 0;
        int          div, exp_lat, ncmd0, exp_cs_hi;
        logic        sck_prev, cs_before, mosi_at_ack;
        logic [31:0] dat, exp_dat;
        logic [23:0] fa;
        bit          seq, fresh;

        div = d ? 3 : 1;
        fa  = 24'((32'h100000 + (a & 32'h00FF_FFFC)) % 32'h0100_0000);
        seq = model_open[d] && (fa == model_next[d]);
        fresh = !wr && !seq;
        if (wr)                exp_lat = 1;
        else if (seq)          exp_lat = 1 + 64 * div;
        else if (model_open[d]) exp_lat = 1 + 4 + 128 * div;
        else                   exp_lat = 1 + 128 * div;
        exp_cs_hi = (!wr && model_open[d] && !seq) ? 4 : 0;

        sel = d[0];
        @(posedge clk); #1;
        ncmd0     = get_ncmd(d);
        cs_before = cs_n_s;
        sck_prev  = sck_s;
        cyc = 1'b1; stb = 1'b1; we = wr; adr = a;
        mosi_at_ack = 1'b0;
        while (lat < 2000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (cs_n_s) cs_hi++;
            if (sck_s && !sck_prev) begin
                rises++;
                if (rises > 1 && (lat - last_rise) != 2 * div) bad_period++;
                last_rise = lat;
            end
            sck_prev = sck_s;
            if (ack_s) begin
                mosi_at_ack = mosi_s;
                break;
            end
        end
        dat = dat_s;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk({tag, " ack_pulse"}, 32'(ack_s), 32'd0);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " sck_rises"}, rises, wr ? 0 : (fresh ? 64 : 32));
        if (wr) begin
            chk({tag, " cs_n_steady"}, cs_hi, cs_before ? lat : 0);
        end else begin
            exp_dat = {mem_rd(fa + 24'd3), mem_rd(fa + 24'd2), mem_rd(fa + 24'd1), mem_rd(fa)};
            chk({tag, " data"}, dat, exp_dat);
            chk({tag, " cs_high_cycles"}, cs_hi, exp_cs_hi);
            chk({tag, " new_cmds"}, get_ncmd(d) - ncmd0, fresh ? 1 : 0);
            if (fresh) chk({tag, " cmd_word"}, get_cmd(d), {8'h03, fa});
            chk({tag, " sck_period"}, bad_period, 0);
            chk({tag, " mosi_data"}, 32'(mosi_at_ack), 32'd0);
            model_open[d] = 1'b1;
            model_next[d] = fa + 24'd4;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acks;
        int d;
        bit wr;
        logic [31:0] a;

        model_open[0] = 1'b0; model_open[1] = 1'b0;
        model_next[0] = 24'd0; model_next[1] = 24'd0;
        mem[32'h100000] = 8'h11; mem[32'h100001] = 8'h22;
        mem[32'h100002] = 8'h33; mem[32'h100003] = 8'h44;
        mem[32'h100004] = 8'h55; mem[32'h100005] = 8'h66;
        mem[32'h100006] = 8'h77; mem[32'h100007] = 8'h88;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d cs_n", i), 32'(cs_n_w[i]), 32'd1);
            chk($sformatf("rst%0d sck", i), 32'(sck_w[i]), 32'd0);
            chk($sformatf("rst%0d mosi", i), 32'(mosi_w[i]), 32'd0);
            chk($sformatf("rst%0d ack", i), 32'(ack_w[i]), 32'd0);
        end
        chk("rst0 dat", dat_w0, 32'd0);
        chk("rst1 dat", dat_w1, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(0, 1'b0, 32'h0000_0000, "fresh_d1");
        chk("fresh_d1 value", dat_w0, 32'h4433_2211);
        do_op(0, 1'b0, 32'h0000_0004, "seq_d1");
        chk("seq_d1 value", dat_w0, 32'h8877_6655);
        do_op(0, 1'b0, 32'h0000_0040, "nonseq_d1");
        do_op(1, 1'b1, 32'h0000_0008, "write_d3");
        do_op(1, 1'b0, 32'h0000_0000, "fresh_d3");
        chk("fresh_d3 value", dat_w1, 32'h4433_2211);
        do_op(0, 1'b0, 32'h00F0_0000, "wrap_a");
        chk("wrap_a cmd", get_cmd(0), 32'h0300_0000);
        do_op(0, 1'b0, 32'h00F0_0004, "wrap_b");

        // reset while shifting in data
        sel = 1'b0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0100;
        repeat (75) @(posedge clk);
        #1;
        chk("rst_mid in_data", g_fl[0].nbits, 32);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid cs_n", 32'(cs_n_w[0]), 32'd1);
        chk("rst_mid sck", 32'(sck_w[0]), 32'd0);
        chk("rst_mid dat", dat_w0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack_w[0]) acks++;
        end
        chk("rst_mid no_ack", acks, 0);
        model_open[0] = 1'b0; model_open[1] = 1'b0;

        // cyc drops while the command is shifting
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0010;
        repeat (20) @(posedge clk);
        #1;
        chk("abort in_cmd", 32'(cs_n_w[0]), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort cs_n", 32'(cs_n_w[0]), 32'd1);
        chk("abort sck", 32'(sck_w[0]), 32'd0);
        chk("abort ack", 32'(ack_w[0]), 32'd0);
        chk("abort dat", dat_w0, 32'd0);
        model_open[0] = 1'b0;
        do_op(0, 1'b0, 32'h0000_0004, "after_abort");
        chk("after_abort value", dat_w0, 32'h8877_6655);

        for (int n = 0; n < 30; n++) begin
            d  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            wr = ($urandom_range(0, 4) == 0);
            if (model_open[d] && $urandom_range(0, 1) == 1)
                a = {8'($urandom), 24'(model_next[d] - 24'h100000)} | 32'($urandom_range(0, 3));
            else
                a = $urandom;
            do_op(d, wr, a, $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
